// File: rtl/tdc_pkg.sv
// Shared types and constants for the ring-oscillator TDC readout.
// Contents: FSM state enum, array/buffer sizes, byte-stream sizes and a
// helper that picks one readout byte out of a captured buffer value.
package tdc_pkg;

  localparam int unsigned TDC_BUF_W    = 19;
  localparam int unsigned TDC_NUM_RO   = 8;
  localparam int unsigned TDC_SEL_W    = 3;
  localparam int unsigned BYTES_PER_RO = 3;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BIDX_W       = 2;
  localparam int unsigned SER_W        = BYTES_PER_RO * BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_SEND  = 3'd5
  } tdc_state_e;

  // Byte idx of the buffer, little-endian; the top byte is zero-extended.
  function automatic logic [BYTE_W-1:0] tdc_byte_sel(input logic [TDC_BUF_W-1:0] cap,
                                                     input logic [BIDX_W-1:0]    idx);
    logic [SER_W-1:0] ext;
    ext = SER_W'(cap);
    case (idx)
      2'd0:    return ext[7:0];
      2'd1:    return ext[15:8];
      default: return ext[23:16];
    endcase
  endfunction

endpackage

// File: rtl/tdc_byte_if.sv
// Valid/ready byte stream from the TDC readout to the chip output path.
//   byte_out   : readout byte
//   byte_valid : byte_out holds a byte
//   byte_ready : consumer accepts the byte on this edge
//   byte_last  : final byte of the whole transaction
interface tdc_byte_if;
  import tdc_pkg::*;

  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;

  modport master (output byte_out, output byte_valid, output byte_last, input byte_ready);
  modport slave  (input byte_out, input byte_valid, input byte_last, output byte_ready);
endinterface

// File: rtl/tdc_byte_ser.sv
// Serialises one captured oscillator buffer into BYTES_PER_RO bytes.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : present byte 0 of cap_i on the next cycle
//   last_ro_i    : this buffer is the final one of the transaction
//   cap_i        : captured buffer, held stable while sending
//   bus          : byte stream master
//   done_ro_c_o  : the final byte of this buffer transfers on this edge
module tdc_byte_ser
  import tdc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 last_ro_i,
  input  logic [TDC_BUF_W-1:0] cap_i,
  tdc_byte_if.master           bus,
  output logic                 done_ro_c_o
);

  localparam logic [BIDX_W-1:0] IDX_LAST = BIDX_W'(BYTES_PER_RO - 1);

  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [BIDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              xfer_c;

  // Next byte is loaded on the transfer edge itself, so no bubble appears.
  always_comb begin
    valid_d     = valid_q;
    last_d      = last_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    done_ro_c_o = 1'b0;
    xfer_c      = valid_q & bus.byte_ready;
    idx_nxt     = idx_q + BIDX_W'(1);
    if (load_i) begin
      valid_d = 1'b1;
      last_d  = 1'b0;
      idx_d   = '0;
      byte_d  = tdc_byte_sel(cap_i, '0);
    end else if (xfer_c) begin
      if (idx_q == IDX_LAST) begin
        valid_d     = 1'b0;
        last_d      = 1'b0;
        done_ro_c_o = 1'b1;
      end else begin
        idx_d  = idx_nxt;
        byte_d = tdc_byte_sel(cap_i, idx_nxt);
        last_d = last_ro_i && (idx_nxt == IDX_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      byte_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
    end
  end

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign bus.byte_last  = last_q;

endmodule

// File: rtl/tdc_readout_ctrl.sv
// Ring-oscillator TDC array controller and reader.
// Sequences deactivate -> activate window -> hold -> clear for one
// oscillator (or all of them in sweep mode), captures the buffer and
// streams it out as bytes.
//   clk, rst       : clock, synchronous active-high reset
//   start, sweep   : launch a measurement (IDLE only); sweep = all oscillators
//   sel_in         : oscillator index for single mode
//   ro_activate    : enable to the TDC array
//   ro_deactivate  : park/clear to the TDC array
//   out_sel        : oscillator index driven to the array
//   buf_in         : selected oscillator buffer
//   bus            : byte stream master
//   busy, done     : not idle / one-cycle completion pulse
module tdc_readout_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned BUF_W         = TDC_BUF_W,
  parameter int unsigned NUM_RO        = TDC_NUM_RO,
  parameter int unsigned ACT_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CLEAR_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sweep,
  input  logic [$clog2(NUM_RO)-1:0] sel_in,
  output logic                      ro_activate,
  output logic                      ro_deactivate,
  output logic [$clog2(NUM_RO)-1:0] out_sel,
  input  logic [BUF_W-1:0]          buf_in,
  tdc_byte_if.master                bus,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned SEL_W   = $clog2(NUM_RO);
  localparam int unsigned MAX_A   = (ACT_CYCLES > SETTLE_CYCLES) ? ACT_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > CLEAR_CYCLES) ? MAX_A : CLEAR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  tdc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sweep_q, sweep_d;
  logic [BUF_W-1:0]   cap_q, cap_d;
  logic               act_q, act_d;
  logic               deact_q, deact_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load_c;
  logic               last_ro_c;
  logic               done_ro_c;

  assign last_ro_c = !sweep_q || (sel_q == SEL_W'(NUM_RO - 1));
  // Serialiser loads on the CLEAR->SEND edge; cap_q is already settled.
  assign load_c    = (state_q == ST_CLEAR) && (cnt_q == CNT_W'(CLEAR_CYCLES - 1));

  // Next-state, phase counter, sweep stepping and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    sweep_d = sweep_q;
    cap_d   = cap_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sweep_d = sweep;
          sel_d   = sweep ? '0 : sel_in;
          cnt_d   = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(ACT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cap_d   = buf_in;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        if (load_c) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (done_ro_c) begin
          if (last_ro_c) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = ST_ARM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    act_d   = (state_d == ST_RUN);
    deact_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_SEND);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      sweep_q <= 1'b0;
      cap_q   <= '0;
      act_q   <= 1'b0;
      deact_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      sweep_q <= sweep_d;
      cap_q   <= cap_d;
      act_q   <= act_d;
      deact_q <= deact_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  tdc_byte_ser u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_c),
    .last_ro_i   (last_ro_c),
    .cap_i       (cap_q),
    .bus         (bus),
    .done_ro_c_o (done_ro_c)
  );

  assign ro_activate   = act_q;
  assign ro_deactivate = deact_q;
  assign out_sel       = sel_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Scoreboard bench for tdc_readout_ctrl: stimulus pushes the expected byte
// sequence, a negedge monitor pops and compares on every transfer and also
// watches the oscillator control sequencing.
module tb_tdc_readout_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sweep;
  logic [2:0]  sel_in;
  logic        ro_activate;
  logic        ro_deactivate;
  logic [2:0]  out_sel;
  logic [18:0] buf_in;
  logic        busy;
  logic        done;
  logic        rdy;
  bit          rand_rdy;

  tdc_byte_if bif ();
  assign bif.byte_ready = rdy;

  logic [18:0] val_tab [8];
  assign buf_in = val_tab[out_sel];

  tdc_readout_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sweep         (sweep),
    .sel_in        (sel_in),
    .ro_activate   (ro_activate),
    .ro_deactivate (ro_deactivate),
    .out_sel       (out_sel),
    .buf_in        (buf_in),
    .bus           (bif),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [8:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops plus control-sequencing properties.
  logic       act_h1 = 1'b0, deact_h1 = 1'b1, deact_h2 = 1'b1;
  logic       rst_prev = 1'b1, v_prev = 1'b0, r_prev = 1'b0;
  logic       last_x_prev = 1'b0, done_prev = 1'b0;
  logic [7:0] b_prev = '0;
  logic [2:0] sel_prev = '0;
  int         act_len = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    logic       xfer;
    xfer = bif.byte_valid && rdy && !rst;
    if (!rst_prev) begin
      chk("bbm_overlap", 32'(ro_activate & ro_deactivate), 32'd0);
      if (ro_activate && !act_h1)
        chk("arm_single_cycle", 32'({deact_h1, deact_h2}), 32'b01);
      if (!ro_activate && act_h1)
        chk("act_len", 32'(act_len), 32'd16);
      if (out_sel != sel_prev)
        chk("sel_change_in_arm", 32'({ro_activate, ro_deactivate}), 32'd0);
      if (v_prev && !r_prev) begin
        chk("stall_valid", 32'(bif.byte_valid), 32'd1);
        chk("stall_byte", 32'(bif.byte_out), 32'(b_prev));
      end
      if (last_x_prev) chk("done_after_last", 32'(done), 32'd1);
      if (bif.byte_last) chk("last_with_valid", 32'(bif.byte_valid), 32'd1);
      if (done) begin
        done_cnt++;
        chk("done_width", 32'(done_prev), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
      end
    end
    if (xfer) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%0h required=none", {bif.byte_last, bif.byte_out});
      end else begin
        e = exp_q.pop_front();
        chk("byte", 32'({bif.byte_last, bif.byte_out}), 32'(e));
      end
    end
    act_len     = ro_activate ? act_len + 1 : 0;
    last_x_prev = xfer && bif.byte_last;
    done_prev   = done;
    act_h1      = ro_activate;
    deact_h2    = deact_h1;
    deact_h1    = ro_deactivate;
    sel_prev    = out_sel;
    v_prev      = bif.byte_valid && !rst;
    r_prev      = rdy;
    b_prev      = bif.byte_out;
    rst_prev    = rst;
  end

  task tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
  endtask

  // Reference: each oscillator yields low, middle, top byte; last flag only
  // on the top byte of the final oscillator of the transaction.
  task automatic push_run(input bit sw, input int sel);
    int lo, hi, v;
    lo = sw ? 0 : sel;
    hi = sw ? 7 : sel;
    for (int r = lo; r <= hi; r++) begin
      v = int'(val_tab[r]);
      exp_q.push_back({1'b0, 8'(v % 256)});
      exp_q.push_back({1'b0, 8'((v / 256) % 256)});
      exp_q.push_back({1'((!sw) || (r == 7)), 8'(v / 65536)});
    end
  endtask

  task automatic launch(input bit sw, input int sel);
    push_run(sw, sel);
    sweep  = sw;
    sel_in = 3'(sel);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!bif.byte_valid && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_valid_seen"}, 32'(bif.byte_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int k;
    logic busy_seen;
    rst = 1'b1; start = 1'b0; sweep = 1'b0; sel_in = '0; rdy = 1'b1; rand_rdy = 1'b0;
    for (int r = 0; r < 8; r++) val_tab[r] = '0;
    tick(); tick();
    chk("rst_act", 32'(ro_activate), 32'd0);
    chk("rst_deact", 32'(ro_deactivate), 32'd1);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_byte", 32'(bif.byte_out), 32'd0);
    chk("rst_valid", 32'(bif.byte_valid), 32'd0);
    chk("rst_last", 32'(bif.byte_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Single mode, sel 5, full-rate consumer.
    val_tab[5] = 19'h5A3C7;
    k = cyc;
    launch(1'b0, 5);
    wait_valid(100, "single");
    chk("latency", 32'(cyc - k), 32'd22);
    chk("single_sel", 32'(out_sel), 32'd5);
    run_to_done(100, "single");
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Backpressure on byte 1.
    val_tab[3] = 19'h5A3C7;
    rdy = 1'b0;
    launch(1'b0, 3);
    wait_valid(100, "bp");
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_byte", 32'(bif.byte_out), 32'hA3);
      chk("bp_hold_valid", 32'(bif.byte_valid), 32'd1);
    end
    rdy = 1'b1;
    run_to_done(100, "bp");
    tick();

    // Sweep all oscillators; sel_in must be ignored.
    for (int r = 0; r < 8; r++) val_tab[r] = 19'h10000 + 19'(r);
    launch(1'b1, 4);
    run_to_done(1000, "sweep");
    tick();

    // Randomised values, modes and consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < 8; r++) val_tab[r] = 19'($urandom);
      launch(i == 2, int'($urandom_range(0, 7)));
      run_to_done(3000, "rand");
      tick();
    end
    rand_rdy = 1'b0;
    rdy = 1'b1;
    tick();

    // Reset during RUN cycle 8, then a clean run.
    val_tab[1] = 19'($urandom);
    launch(1'b0, 1);
    k = 0;
    while (!ro_activate && k < 50) begin tick(); k++; end
    chk("mid_run_act_seen", 32'(ro_activate), 32'd1);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("abort_act", 32'(ro_activate), 32'd0);
    chk("abort_deact", 32'(ro_deactivate), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(bif.byte_valid), 32'd0);
    tick();
    launch(1'b0, 1);
    run_to_done(100, "post_reset");
    tick();

    // start while in SEND is ignored.
    val_tab[2] = 19'($urandom);
    val_tab[6] = 19'($urandom);
    rdy = 1'b0;
    launch(1'b0, 2);
    wait_valid(100, "send_start");
    sel_in = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    rdy = 1'b1;
    run_to_done(100, "send_start");
    tick();
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); busy_seen |= busy; end
    chk("no_relaunch", 32'(busy_seen), 32'd0);

    // start and rst together: reset wins.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); busy_seen |= busy | ro_activate; end
    chk("start_rst_ignored", 32'(busy_seen), 32'd0);

    repeat (3) tick();
    chk("done_count", 32'(done_cnt), 32'd10);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
